// File: rtl/l2_writeback_buffer_pkg.sv
// Shared types for the L2 writeback buffer.
// Entry layout, drain states and line geometry.
package l2_writeback_buffer_pkg;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;
    localparam int TAG_BITS    = 32 - OFFSET_BITS;

    typedef enum logic [0:0] {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 draining;
        logic [TAG_BITS-1:0]  tag;
        logic [LINE_BITS-1:0] data;
    } wb_entry_t;

    function automatic logic [TAG_BITS-1:0] line_tag(input logic [31:0] addr);
        return addr[31:OFFSET_BITS];
    endfunction

endpackage

// File: rtl/l2_writeback_buffer_wb_match_find.sv
// Tag compare across all buffer slots.
// Youngest candidate (closest to tail) wins on multiple matches.
module wb_match_find
    import l2_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]    cand,
    input  logic [TAG_BITS-1:0] tags [DEPTH],
    input  logic [PTR_W-1:0]    tail,
    input  logic [TAG_BITS-1:0] tag,
    output logic                hit,
    output logic [PTR_W-1:0]    idx
);

    logic [PTR_W-1:0] slot;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            slot = tail - PTR_W'(k);
            if (cand[slot] && tags[slot] == tag) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/l2_writeback_buffer.sv
// Circular buffer of dirty L2 lines draining to pmem,
// with coalescing on write and a combinational miss lookup.
module l2_writeback_buffer
    import l2_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_write,
    input  logic [31:0]  wb_addr,
    input  logic [255:0] wb_wdata,
    output logic         wb_resp,
    input  logic [31:0]  lookup_addr,
    output logic         lookup_hit,
    output logic [255:0] lookup_rdata,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    output logic         full,
    output logic         empty
);

    wb_entry_t           entries [DEPTH];
    logic [TAG_BITS-1:0] tags [DEPTH];
    logic [DEPTH-1:0]    look_cand;
    logic [DEPTH-1:0]    coal_cand;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;
    logic [PTR_W:0]      count_next;
    wb_state_t           state;

    logic                co_hit;
    logic [PTR_W-1:0]    co_idx;
    logic                lk_hit;
    logic [PTR_W-1:0]    lk_idx;
    logic                accept;
    logic                do_coal;
    logic                do_push;
    logic                do_pop;
    logic                load;
    logic [PTR_W-1:0]    next_head;
    logic                push_fwd;
    logic                coal_fwd;
    logic [TAG_BITS-1:0] ld_tag;
    logic [255:0]        ld_data;
    logic                unused_offsets;

    assign unused_offsets = ^{wb_addr[4:0], lookup_addr[4:0]};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tags[i]      = entries[i].tag;
            look_cand[i] = entries[i].valid;
            coal_cand[i] = entries[i].valid & ~entries[i].draining;
        end
    end

    wb_match_find #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_coal_find (
        .cand (coal_cand),
        .tags (tags),
        .tail (tail),
        .tag  (line_tag(wb_addr)),
        .hit  (co_hit),
        .idx  (co_idx)
    );

    wb_match_find #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_look_find (
        .cand (look_cand),
        .tags (tags),
        .tail (tail),
        .tag  (line_tag(lookup_addr)),
        .hit  (lk_hit),
        .idx  (lk_idx)
    );

    assign lookup_hit   = lk_hit;
    assign lookup_rdata = lk_hit ? entries[lk_idx].data : '0;

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign pmem_write = (state == WB_DRAIN);

    assign accept     = wb_write && !wb_resp;
    assign do_coal    = accept && co_hit;
    assign do_push    = accept && !co_hit && !full;
    assign do_pop     = pmem_write && pmem_resp;
    assign count_next = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    assign next_head  = do_pop ? head + 1'b1 : head;
    assign load       = (state == WB_IDLE && !empty)
                     || (do_pop && count_next != '0);

    // The line being loaded may be written on this same edge; forward it.
    assign push_fwd = do_push && (tail == next_head);
    assign coal_fwd = do_coal && (co_idx == next_head);
    assign ld_tag   = push_fwd ? line_tag(wb_addr) : entries[next_head].tag;
    assign ld_data  = (push_fwd || coal_fwd) ? wb_wdata
                                             : entries[next_head].data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            state        <= WB_IDLE;
            wb_resp      <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            wb_resp <= do_coal || do_push;
            count   <= count_next;
            if (do_coal) entries[co_idx].data <= wb_wdata;
            if (do_push) begin
                entries[tail].valid    <= 1'b1;
                entries[tail].draining <= 1'b0;
                entries[tail].tag      <= line_tag(wb_addr);
                entries[tail].data     <= wb_wdata;
                tail                   <= tail + 1'b1;
            end
            if (do_pop) begin
                entries[head].valid    <= 1'b0;
                entries[head].draining <= 1'b0;
                head                   <= head + 1'b1;
            end
            if (load) begin
                entries[next_head].draining <= 1'b1;
                pmem_address <= {ld_tag, {OFFSET_BITS{1'b0}}};
                pmem_wdata   <= ld_data;
                state        <= WB_DRAIN;
            end else if (do_pop) begin
                state <= WB_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed bench for l2_writeback_buffer with a drain scoreboard.
// Expected pmem writes are queued at issue and popped by a monitor.
module tb_l2_writeback_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_write;
    logic [31:0]  wb_addr;
    logic [255:0] wb_wdata;
    logic         wb_resp;
    logic [31:0]  lookup_addr;
    logic         lookup_hit;
    logic [255:0] lookup_rdata;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic         full;
    logic         empty;

    l2_writeback_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_write     (wb_write),
        .wb_addr      (wb_addr),
        .wb_wdata     (wb_wdata),
        .wb_resp      (wb_resp),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_rdata (lookup_rdata),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mem_auto = 1'b0;
    int   mem_lat  = 3;
    int   lat_cnt  = 0;
    logic auto_resp = 1'b0;
    logic manual_resp;

    assign pmem_resp = mem_auto ? auto_resp : manual_resp;

    function automatic logic [255:0] pat(input logic [31:0] k);
        return {8{k}};
    endfunction

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers each drain after mem_lat cycles when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            auto_resp = 1'b0;
            if (mem_auto && pmem_write) begin
                if (lat_cnt == mem_lat - 1) begin
                    auto_resp = 1'b1;
                    lat_cnt   = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Drain monitor: each completed pmem write must match the queue head.
    always @(negedge clk) begin
        if (!rst && pmem_write && pmem_resp) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_unexpected: got address %h expected none",
                         pmem_address);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("drain_addr", 256'(pmem_address), 256'(e.addr));
                check("drain_data", pmem_wdata, e.data);
            end
        end
    end

    task automatic wb_send(input logic [31:0] a, input logic [255:0] d,
                           input string name);
        int lat = 0;
        @(posedge clk);
        #1;
        wb_write = 1'b1;
        wb_addr  = a;
        wb_wdata = d;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!wb_resp && lat < 20);
        check({name, "_latency"}, 256'(lat), 256'(1));
        @(posedge clk);
        #1;
        wb_write = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((!empty || pmem_write) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 256'({empty, pmem_write}), 256'(2'b10));
        check({name, "_queue"}, 256'(exp_q.size()), 256'(0));
    endtask

    task automatic look(input logic [31:0] a, input logic hit,
                        input logic [255:0] d, input string name);
        lookup_addr = a;
        #1;
        check({name, "_hit"}, 256'(lookup_hit), 256'(hit));
        check({name, "_rdata"}, lookup_rdata, d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        bit seen;
        rst         = 1'b1;
        wb_write    = 1'b0;
        wb_addr     = '0;
        wb_wdata    = '0;
        lookup_addr = '0;
        manual_resp = 1'b0;
        #12;
        check("rst_wb_resp", 256'(wb_resp), 256'(0));
        check("rst_pmem_write", 256'(pmem_write), 256'(0));
        check("rst_pmem_address", 256'(pmem_address), 256'(0));
        check("rst_pmem_wdata", pmem_wdata, 256'(0));
        check("rst_flags", 256'({full, empty}), 256'(2'b01));
        check("rst_lookup_hit", 256'(lookup_hit), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single eviction drained with 3-cycle memory latency.
        mem_auto = 1'b1;
        exp_q.push_back('{addr: 32'h0000_1040, data: pat(32'hA0A0_0001)});
        wb_send(32'h0000_1040, pat(32'hA0A0_0001), "single");
        wait_idle("single");

        // Fill to full with memory stalled; fifth write waits for a pop.
        mem_auto = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h5000 + 32'(i * 32);
            if (i == 3) a = a | 32'h1F;
            exp_q.push_back('{addr: a & ~32'h1F, data: pat(32'h5000_0000 + 32'(i))});
            wb_send(a, pat(32'h5000_0000 + 32'(i)), "fill");
        end
        check("fill_flags", 256'({full, empty}), 256'(2'b10));
        exp_q.push_back('{addr: 32'h5080, data: pat(32'h5000_0004)});
        @(posedge clk);
        #1;
        wb_write = 1'b1;
        wb_addr  = 32'h5080;
        wb_wdata = pat(32'h5000_0004);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_resp) seen = 1'b1;
        end
        check("full_refuse", 256'(seen), 256'(0));
        @(posedge clk);
        #1;
        manual_resp = 1'b1;
        @(posedge clk);
        #1;
        manual_resp = 1'b0;
        check("full_pop_resp", 256'(wb_resp), 256'(0));
        check("full_pop_full", 256'(full), 256'(0));
        @(posedge clk);
        #1;
        check("full_late_resp", 256'(wb_resp), 256'(1));
        @(posedge clk);
        #1;
        wb_write = 1'b0;
        mem_auto = 1'b1;
        wait_idle("fill");

        // Coalesce behind a stalled drain; lookup priorities.
        mem_auto = 1'b0;
        exp_q.push_back('{addr: 32'h3000, data: pat(32'hC0C0_0000)});
        wb_send(32'h3000, pat(32'hC0C0_0000), "drain_head");
        check("drain_busy", 256'({pmem_write, pmem_address}),
              256'({1'b1, 32'h3000}));
        look(32'h3000, 1'b1, pat(32'hC0C0_0000), "look_draining");
        look(32'h4000, 1'b0, 256'(0), "look_miss");
        wb_send(32'h2000, pat(32'hAAAA_0001), "coal_a");
        wb_send(32'h2000, pat(32'hBBBB_0002), "coal_b");
        exp_q.push_back('{addr: 32'h2000, data: pat(32'hBBBB_0002)});
        look(32'h2010, 1'b1, pat(32'hBBBB_0002), "look_coal");
        wb_send(32'h3000, pat(32'hEEEE_0003), "young");
        exp_q.push_back('{addr: 32'h3000, data: pat(32'hEEEE_0003)});
        check("coal_count3", 256'(full), 256'(0));
        look(32'h3000, 1'b1, pat(32'hEEEE_0003), "look_youngest");
        wb_send(32'h7000, pat(32'hDDDD_0004), "coal_fill");
        exp_q.push_back('{addr: 32'h7000, data: pat(32'hDDDD_0004)});
        check("coal_count4", 256'(full), 256'(1));
        mem_auto = 1'b1;
        wait_idle("coal");

        // Push and pop on the same edge at count 2, six times to wrap.
        mem_auto = 1'b0;
        exp_q.push_back('{addr: 32'h8000, data: pat(32'h8000_0000)});
        wb_send(32'h8000, pat(32'h8000_0000), "pp_l0");
        exp_q.push_back('{addr: 32'h8020, data: pat(32'h8000_0001)});
        wb_send(32'h8020, pat(32'h8000_0001), "pp_l1");
        for (int i = 0; i < 6; i++) begin
            a = 32'hA000 + 32'(i * 32);
            exp_q.push_back('{addr: a, data: pat(32'hA000_0000 + 32'(i))});
            @(posedge clk);
            #1;
            wb_write    = 1'b1;
            wb_addr     = a;
            wb_wdata    = pat(32'hA000_0000 + 32'(i));
            manual_resp = 1'b1;
            @(posedge clk);
            #1;
            wb_write    = 1'b0;
            manual_resp = 1'b0;
            check("pp_resp", 256'(wb_resp), 256'(1));
            check("pp_flags", 256'({full, empty}), 256'(2'b00));
        end
        look(32'hA080, 1'b1, pat(32'hA000_0004), "pp_look4");
        look(32'hA0A0, 1'b1, pat(32'hA000_0005), "pp_look5");
        look(32'hA060, 1'b0, 256'(0), "pp_look3");
        exp_q.push_back('{addr: 32'hB000, data: pat(32'hB000_0000)});
        wb_send(32'hB000, pat(32'hB000_0000), "pp_b0");
        check("pp_count3", 256'(full), 256'(0));
        exp_q.push_back('{addr: 32'hB020, data: pat(32'hB000_0001)});
        wb_send(32'hB020, pat(32'hB000_0001), "pp_b1");
        check("pp_count4", 256'(full), 256'(1));
        mem_auto = 1'b1;
        wait_idle("pp");

        // Asynchronous reset in the middle of a drain.
        mem_auto = 1'b0;
        wb_send(32'h9000, pat(32'h9000_0000), "rst_line");
        check("rst_pre_drain", 256'(pmem_write), 256'(1));
        lookup_addr = 32'h9000;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pmem_write", 256'(pmem_write), 256'(0));
        check("arst_flags", 256'({full, empty}), 256'(2'b01));
        check("arst_lookup_hit", 256'(lookup_hit), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("arst_queue", 256'(exp_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
